mr_wb_arb: RTL and testbench
============================

Name: mr_wb_arb

Overview:
Two-master to one-slave pipelined Wishbone arbiter, directly downstream of the core's two bus masters.
- Port 0 is driven by the ifetch master (wbm0 of the core); port 1 by the load/store master (wbm1).
- The arbiter presents one pipelined Wishbone master to the memory/peripheral fabric.
- It tracks outstanding requests so that a grant is only handed over after all acks have returned.

Parameters:
AW, 30, address width in words (XLEN-XLEN_GRAN)
DW, 32, data width (XLEN)
MAX_OUT, 4, max outstanding accepted-but-unacked requests per grant (power of 2, >=1)
ROUND_ROBIN, 0, 0 = port 1 always wins ties; 1 = tie goes to the port not granted last
TIMEOUT, 255, cycles with no ack/err (while outstanding>0) before forced error; only used with the optional feature

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wbs0_adr_i  in  AW  port 0 address
wbs0_dat_i  in  DW  port 0 write data
wbs0_dat_o  out  DW  port 0 read data
wbs0_we_i  in  1  port 0 write enable
wbs0_sel_i  in  DW/8  port 0 byte select
wbs0_stb_i  in  1  port 0 strobe
wbs0_cyc_i  in  1  port 0 cycle
wbs0_ack_o  out  1  port 0 ack
wbs0_err_o  out  1  port 0 error
wbs0_stall_o  out  1  port 0 stall
wbs1_*  (same eight signals as wbs0_*)  port 1 (ldst)
wbm_adr_o  out  AW  fabric address
wbm_dat_o  out  DW  fabric write data
wbm_dat_i  in  DW  fabric read data
wbm_we_o  out  1  fabric write enable
wbm_sel_o  out  DW/8  fabric byte select
wbm_stb_o  out  1  fabric strobe
wbm_cyc_o  out  1  fabric cycle
wbm_ack_i  in  1  fabric ack
wbm_err_i  in  1  fabric error
wbm_stall_i  in  1  fabric stall

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, outstanding count cnt=0, last-grant pointer=0.
  - wbm_cyc_o=0, wbm_stb_o=0.
  - wbs*_stall_o=1, wbs*_ack_o=0, wbs*_err_o=0.
  - adr/dat/we/sel outputs=0.
- States IDLE, G0, G1; the grant is registered.
- IDLE:
  - Nothing forwarded; both stall_o=1.
  - Next edge: both cyc high -> G1 (ROUND_ROBIN=0) or the port not equal to last-grant (ROUND_ROBIN=1).
  - Only one cyc high -> that port.
  - Arbitration latency: 1 cycle from cyc to first possible acceptance.
- Gx, request path:
  - wbm_cyc_o = wbsx_cyc_i.
  - adr/dat/we/sel muxed from port x.
  - wbm_stb_o = wbsx_stb_i & ~full, where full = (cnt==MAX_OUT).
  - wbsx_stall_o = wbm_stall_i | full; the other port's stall_o=1.
- Gx, response path:
  - wbsx_ack_o = wbm_ack_i and wbsx_err_o = wbm_err_i, combinational pass-through.
  - The other port's ack/err = 0.
  - wbm_dat_i is broadcast to both dat_o.
- Counter:
  - Increments on accept (wbm_stb_o & ~wbm_stall_i); decrements on wbm_ack_i|wbm_err_i.
  - Both in the same cycle -> unchanged.
  - Never exceeds MAX_OUT.
  - ack/err arriving with cnt==0 is dropped (not forwarded).
- Release from Gx:
  - Normal release when wbsx_cyc_i=0 and cnt==0, or when cnt would reach 0 this cycle and cyc falls.
  - If the other port's cyc is high -> go directly to G(other) next edge; else -> IDLE.
  - Last-grant updates to x.
- Abort: if wbsx_cyc_i drops while cnt>0:
  - wbm_cyc_o drops the same cycle; cnt clears to 0 next edge; state -> IDLE.
  - Late fabric acks are dropped because cnt==0.
- No grant preemption: port 1 cannot take the bus while G0 is active and port 0 holds cyc.
- Reset mid-transaction: everything returns to reset values immediately; in-flight responses are discarded.

Optional Feature:
Macro: MR_WB_ARB_TIMEOUT_EN
- Defined:
  - A timeout counter resets to 0 on any ack/err, on grant change, or when cnt==0.
  - It increments each cycle while cnt>0.
  - On reaching TIMEOUT: one-cycle wbsx_err_o=1 to the granted port, wbm_cyc_o forced 0 that cycle, cnt cleared, state -> IDLE.
- Not defined: no timeout counter; the arbiter waits indefinitely for ack/err.

Test Plan:
1. Reset then idle: rst pulse, no cyc -> wbm_cyc_o=0, wbs0/1_stall_o=1, all ack/err 0.
2. Single port-0 burst: cyc0+stb0 for 3 reads adr 0x10,0x11,0x12, fabric acks 2 cycles later each -> G0 one cycle after cyc0; wbm_adr_o sequence 0x10..0x12; three acks only on wbs0_ack_o; cnt returns 0; IDLE after cyc0 drops.
3. Contention, ROUND_ROBIN=0: cyc0 and cyc1 rise same cycle -> G1 first; port 0 stall_o=1 until port 1 drops cyc; then direct handoff to G0 with no IDLE cycle.
4. Outstanding limit: MAX_OUT=4, port 1 issues 6 stb with acks withheld -> exactly 4 accepted, wbs1_stall_o=1 and wbm_stb_o=0 while cnt==4; one ack -> 5th accepted next cycle.
5. Abort: port 0 has 2 outstanding, drops cyc0 -> wbm_cyc_o=0 same cycle, then 2 late wbm_ack_i -> no wbs0/1_ack_o pulses, state IDLE.
6. Timeout (MR_WB_ARB_TIMEOUT_EN, TIMEOUT=8): port 1 single write, fabric never acks -> wbs1_err_o=1 exactly 8 cycles after acceptance; cnt=0; IDLE next cycle.

Source files
------------

// File: rtl/mr_wb_arb.sv
`default_nettype none
// ============================================================================
// mr_wb_arb : two-master to one-slave pipelined Wishbone arbiter that holds a
//             grant until every accepted request has been acked.
// Optional  : define MR_WB_ARB_TIMEOUT_EN to enable the missing-ack timeout.
// Revision  : 1.0
// ============================================================================
module mr_wb_arb #(
    parameter int AW          = 30,
    parameter int DW          = 32,
    parameter int MAX_OUT     = 4,
    parameter int ROUND_ROBIN = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   wbs0_adr_i,
    input  logic [DW-1:0]   wbs0_dat_i,
    output logic [DW-1:0]   wbs0_dat_o,
    input  logic            wbs0_we_i,
    input  logic [DW/8-1:0] wbs0_sel_i,
    input  logic            wbs0_stb_i,
    input  logic            wbs0_cyc_i,
    output logic            wbs0_ack_o,
    output logic            wbs0_err_o,
    output logic            wbs0_stall_o,
    input  logic [AW-1:0]   wbs1_adr_i,
    input  logic [DW-1:0]   wbs1_dat_i,
    output logic [DW-1:0]   wbs1_dat_o,
    input  logic            wbs1_we_i,
    input  logic [DW/8-1:0] wbs1_sel_i,
    input  logic            wbs1_stb_i,
    input  logic            wbs1_cyc_i,
    output logic            wbs1_ack_o,
    output logic            wbs1_err_o,
    output logic            wbs1_stall_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic            wbm_stb_o,
    output logic            wbm_cyc_o,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i,
    input  logic            wbm_stall_i
);

    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;

    logic g0, g1, cyc_x, stb_x, other_cyc;
    logic full, pending, rsp_in, resp, accept, timeout_hit;

    assign g0        = (state == G0);
    assign g1        = (state == G1);
    assign cyc_x     = (g0 & wbs0_cyc_i) | (g1 & wbs1_cyc_i);
    assign stb_x     = (g0 & wbs0_stb_i) | (g1 & wbs1_stb_i);
    assign other_cyc = g0 ? wbs1_cyc_i : wbs0_cyc_i;
    assign full      = (cnt == CW'(MAX_OUT));
    assign pending   = (cnt != '0);
    assign rsp_in    = wbm_ack_i | wbm_err_i;
    // Responses with nothing outstanding belong to an aborted grant: drop them.
    assign resp      = pending & rsp_in;
    assign accept    = wbm_stb_o & ~wbm_stall_i;

    always_comb begin
        wbm_adr_o = '0;
        wbm_dat_o = '0;
        wbm_we_o  = 1'b0;
        wbm_sel_o = '0;
        if (g0) begin
            wbm_adr_o = wbs0_adr_i;
            wbm_dat_o = wbs0_dat_i;
            wbm_we_o  = wbs0_we_i;
            wbm_sel_o = wbs0_sel_i;
        end else if (g1) begin
            wbm_adr_o = wbs1_adr_i;
            wbm_dat_o = wbs1_dat_i;
            wbm_we_o  = wbs1_we_i;
            wbm_sel_o = wbs1_sel_i;
        end
    end

    assign wbm_cyc_o    = cyc_x & ~timeout_hit;
    assign wbm_stb_o    = stb_x & ~full & ~timeout_hit;

    assign wbs0_dat_o   = wbm_dat_i;
    assign wbs1_dat_o   = wbm_dat_i;
    assign wbs0_ack_o   = g0 & wbm_ack_i & pending;
    assign wbs1_ack_o   = g1 & wbm_ack_i & pending;
    assign wbs0_err_o   = g0 & ((wbm_err_i & pending) | timeout_hit);
    assign wbs1_err_o   = g1 & ((wbm_err_i & pending) | timeout_hit);
    assign wbs0_stall_o = ~g0 | wbm_stall_i | full;
    assign wbs1_stall_o = ~g1 | wbm_stall_i | full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (wbs0_cyc_i && wbs1_cyc_i)
                        state <= (ROUND_ROBIN != 0 && last) ? G0 : G1;
                    else if (wbs0_cyc_i)
                        state <= G0;
                    else if (wbs1_cyc_i)
                        state <= G1;
                end
                G0, G1: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                        cnt   <= '0;
                        last  <= g1;
                    end else if (!cyc_x) begin
                        // Clean release may hand straight over; abort always idles.
                        cnt  <= '0;
                        last <= g1;
                        if (pending && !(cnt == CW'(1) && resp))
                            state <= IDLE;
                        else if (other_cyc)
                            state <= g0 ? G1 : G0;
                        else
                            state <= IDLE;
                    end else if (accept && !resp) begin
                        cnt <= cnt + CW'(1);
                    end else if (!accept && resp) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef MR_WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt;

    // Fires on the TIMEOUT-th silent cycle after the oldest unanswered accept.
    assign timeout_hit = pending & cyc_x & ~rsp_in & (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tcnt <= '0;
        else if (!pending || rsp_in || !cyc_x || timeout_hit)
            tcnt <= '0;
        else
            tcnt <= tcnt + TW'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mr_wb_arb.sv
`default_nettype none
// Self-checking bench for mr_wb_arb: directed vector table, corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_mr_wb_arb;
    localparam int AW = 30, DW = 32, MAX_OUT = 4, TIMEOUT = 8;

    logic clk = 1'b0, rst;
    logic [AW-1:0] wbs0_adr_i, wbs1_adr_i, wbm_adr_o;
    logic [DW-1:0] wbs0_dat_i, wbs0_dat_o, wbs1_dat_i, wbs1_dat_o, wbm_dat_o, wbm_dat_i;
    logic [DW/8-1:0] wbs0_sel_i, wbs1_sel_i, wbm_sel_o;
    logic wbs0_we_i, wbs0_stb_i, wbs0_cyc_i, wbs0_ack_o, wbs0_err_o, wbs0_stall_o;
    logic wbs1_we_i, wbs1_stb_i, wbs1_cyc_i, wbs1_ack_o, wbs1_err_o, wbs1_stall_o;
    logic wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i, wbm_err_i, wbm_stall_i;

    mr_wb_arb #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT), .ROUND_ROBIN(0), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .wbs0_adr_i(wbs0_adr_i), .wbs0_dat_i(wbs0_dat_i), .wbs0_dat_o(wbs0_dat_o),
        .wbs0_we_i(wbs0_we_i), .wbs0_sel_i(wbs0_sel_i), .wbs0_stb_i(wbs0_stb_i),
        .wbs0_cyc_i(wbs0_cyc_i), .wbs0_ack_o(wbs0_ack_o), .wbs0_err_o(wbs0_err_o),
        .wbs0_stall_o(wbs0_stall_o),
        .wbs1_adr_i(wbs1_adr_i), .wbs1_dat_i(wbs1_dat_i), .wbs1_dat_o(wbs1_dat_o),
        .wbs1_we_i(wbs1_we_i), .wbs1_sel_i(wbs1_sel_i), .wbs1_stb_i(wbs1_stb_i),
        .wbs1_cyc_i(wbs1_cyc_i), .wbs1_ack_o(wbs1_ack_o), .wbs1_err_o(wbs1_err_o),
        .wbs1_stall_o(wbs1_stall_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .wbm_stall_i(wbm_stall_i)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic c0, s0, c1, s1, ack, err, stall);
        wbs0_cyc_i = c0; wbs0_stb_i = s0; wbs1_cyc_i = c1; wbs1_stb_i = s1;
        wbm_ack_i = ack; wbm_err_i = err; wbm_stall_i = stall;
    endtask

    typedef struct {
        logic c0, s0, c1, s1, ack, stall;
        logic ecyc, estb, est0, est1, eack0, eack1;
        logic [AW-1:0] eadr;
    } vec_t;
    vec_t tbl [10];

    // Reference model state: grant (-1 none), queue of accepted addresses.
    int mg;
    logic [AW-1:0] mq [$];
    int wait_cnt;

    task automatic model_check(input int t);
        int n;
        logic full, cg, sg;
        logic [AW-1:0] ag;
        n = mq.size();
        full = (n == MAX_OUT);
        cg = (mg == 0) ? wbs0_cyc_i : wbs1_cyc_i;
        sg = (mg == 0) ? wbs0_stb_i : wbs1_stb_i;
        ag = (mg == 0) ? wbs0_adr_i : wbs1_adr_i;
        if (mg < 0) begin
            check($sformatf("rnd%0d cyc", t), wbm_cyc_o, 0);
            check($sformatf("rnd%0d stb", t), wbm_stb_o, 0);
            check($sformatf("rnd%0d stall0", t), wbs0_stall_o, 1);
            check($sformatf("rnd%0d stall1", t), wbs1_stall_o, 1);
            check($sformatf("rnd%0d ackerr", t),
                  {wbs0_ack_o, wbs1_ack_o, wbs0_err_o, wbs1_err_o}, 0);
        end else begin
            check($sformatf("rnd%0d cyc", t), wbm_cyc_o, cg);
            check($sformatf("rnd%0d stb", t), wbm_stb_o, sg & ~full);
            check($sformatf("rnd%0d adr", t), wbm_adr_o, ag);
            check($sformatf("rnd%0d stall0", t), wbs0_stall_o,
                  (mg == 0) ? (wbm_stall_i | full) : 1'b1);
            check($sformatf("rnd%0d stall1", t), wbs1_stall_o,
                  (mg == 1) ? (wbm_stall_i | full) : 1'b1);
            check($sformatf("rnd%0d ack0", t), wbs0_ack_o, (mg == 0) && wbm_ack_i && n > 0);
            check($sformatf("rnd%0d ack1", t), wbs1_ack_o, (mg == 1) && wbm_ack_i && n > 0);
            check($sformatf("rnd%0d err0", t), wbs0_err_o, (mg == 0) && wbm_err_i && n > 0);
            check($sformatf("rnd%0d err1", t), wbs1_err_o, (mg == 1) && wbm_err_i && n > 0);
        end
        check($sformatf("rnd%0d dat", t), {wbs0_dat_o, wbs1_dat_o}, {wbm_dat_i, wbm_dat_i});
    endtask

    task automatic model_step();
        int n;
        logic resp, cg, sg, oc;
        logic [AW-1:0] ag;
        n = mq.size();
        resp = (wbm_ack_i | wbm_err_i) && n > 0 && mg >= 0;
        if (mg < 0) begin
            mq.delete();
            if (wbs1_cyc_i) mg = 1;
            else if (wbs0_cyc_i) mg = 0;
        end else begin
            cg = (mg == 0) ? wbs0_cyc_i : wbs1_cyc_i;
            sg = (mg == 0) ? wbs0_stb_i : wbs1_stb_i;
            ag = (mg == 0) ? wbs0_adr_i : wbs1_adr_i;
            oc = (mg == 0) ? wbs1_cyc_i : wbs0_cyc_i;
            if (!cg) begin
                if (n == 0 || (n == 1 && resp)) mg = oc ? 1 - mg : -1;
                else mg = -1;
                mq.delete();
            end else begin
                if (resp) void'(mq.pop_front());
                if (sg && n < MAX_OUT && !wbm_stall_i) mq.push_back(ag);
            end
        end
    endtask

    initial begin
        int acc;
        wbs0_adr_i = 'h10; wbs1_adr_i = 'h20; wbs0_dat_i = 0; wbs1_dat_i = 0;
        wbs0_we_i = 0; wbs1_we_i = 0; wbs0_sel_i = '1; wbs1_sel_i = '1; wbm_dat_i = 0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick(); tick();
        check("reset cyc", wbm_cyc_o, 0);
        check("reset stb", wbm_stb_o, 0);
        check("reset stall", {wbs0_stall_o, wbs1_stall_o}, 2'b11);
        check("reset ackerr", {wbs0_ack_o, wbs1_ack_o, wbs0_err_o, wbs1_err_o}, 0);
        check("reset adr", wbm_adr_o, 0);
        rst = 1'b0;
        tick();

        // Contention, direct handoff, stall pass-through, dropped stray ack.
        tbl[0] = '{0,0,0,0,0,0, 0,0,1,1,0,0, 'h0};
        tbl[1] = '{1,1,1,1,0,0, 0,0,1,1,0,0, 'h0};
        tbl[2] = '{1,1,1,1,0,0, 1,1,1,0,0,0, 'h20};
        tbl[3] = '{1,1,1,0,1,0, 1,0,1,0,0,1, 'h20};
        tbl[4] = '{1,1,0,0,0,0, 0,0,1,0,0,0, 'h20};
        tbl[5] = '{1,1,0,0,0,0, 1,1,0,1,0,0, 'h10};
        tbl[6] = '{1,0,0,0,0,1, 1,0,1,1,0,0, 'h10};
        tbl[7] = '{1,0,0,0,1,0, 1,0,0,1,1,0, 'h10};
        tbl[8] = '{0,0,0,0,0,0, 0,0,0,1,0,0, 'h10};
        tbl[9] = '{0,0,0,0,1,0, 0,0,1,1,0,0, 'h0};
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack, 0, tbl[i].stall);
            #2;
            check($sformatf("tbl%0d cyc", i), wbm_cyc_o, tbl[i].ecyc);
            check($sformatf("tbl%0d stb", i), wbm_stb_o, tbl[i].estb);
            check($sformatf("tbl%0d stall0", i), wbs0_stall_o, tbl[i].est0);
            check($sformatf("tbl%0d stall1", i), wbs1_stall_o, tbl[i].est1);
            check($sformatf("tbl%0d ack0", i), wbs0_ack_o, tbl[i].eack0);
            check($sformatf("tbl%0d ack1", i), wbs1_ack_o, tbl[i].eack1);
            check($sformatf("tbl%0d adr", i), wbm_adr_o, tbl[i].eadr);
            @(posedge clk); #1;
        end

        // Outstanding limit: port 1 keeps strobing with acks withheld.
        set_in(0, 0, 1, 1, 0, 0, 0);
        tick();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            #2;
            if (wbm_stb_o && !wbm_stall_i) acc++;
            if (i >= 4) begin
                check($sformatf("limit%0d stall1", i), wbs1_stall_o, 1);
                check($sformatf("limit%0d stb", i), wbm_stb_o, 0);
            end
            @(posedge clk); #1;
        end
        check("limit accepted", acc, 4);
        wbm_ack_i = 1; #2;
        check("limit ack1", wbs1_ack_o, 1);
        check("limit stb at ack", wbm_stb_o, 0);
        @(posedge clk); #1;
        wbm_ack_i = 0; #2;
        check("limit 5th stb", wbm_stb_o, 1);
        check("limit 5th stall1", wbs1_stall_o, 0);
        @(posedge clk); #1;
        set_in(0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #2; check($sformatf("drain%0d ack1", i), wbs1_ack_o, 1);
            @(posedge clk); #1;
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("limit idle stall1", wbs1_stall_o, 1);

        // Abort with two outstanding; late acks must vanish.
        set_in(1, 1, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        set_in(0, 0, 0, 0, 0, 0, 0); #2;
        check("abort cyc", wbm_cyc_o, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            wbm_ack_i = 1; #2;
            check($sformatf("abort late ack%0d", i), {wbs0_ack_o, wbs1_ack_o}, 0);
            check($sformatf("abort idle%0d", i), {wbs0_stall_o, wbs1_stall_o}, 2'b11);
            @(posedge clk); #1;
        end
        wbm_ack_i = 0;

`ifdef MR_WB_ARB_TIMEOUT_EN
        // Single write on port 1 never acked.
        wbs1_we_i = 1;
        set_in(0, 0, 1, 1, 0, 0, 0);
        tick();
        #2; check("to accept", wbm_stb_o, 1);
        @(posedge clk); #1;
        wbs1_stb_i = 0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            #2;
            check($sformatf("to err1 c%0d", k), wbs1_err_o, k == TIMEOUT);
            if (k == TIMEOUT) check("to cyc forced", wbm_cyc_o, 0);
            @(posedge clk); #1;
        end
        wbs1_cyc_i = 0; wbs1_we_i = 0; #2;
        check("to idle stall1", wbs1_stall_o, 1);
        check("to idle err1", wbs1_err_o, 0);
        @(posedge clk); #1;
`endif

        // Reset in mid-transaction takes effect without a clock edge.
        set_in(1, 1, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b1; wbm_ack_i = 1; #1;
        check("midrst cyc", wbm_cyc_o, 0);
        check("midrst stall0", wbs0_stall_o, 1);
        check("midrst ack0", wbs0_ack_o, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // Randomized traffic against the reference model.
        mg = -1; mq.delete(); wait_cnt = 0;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(7) == 0) wbs0_cyc_i = ~wbs0_cyc_i;
            if ($urandom_range(7) == 0) wbs1_cyc_i = ~wbs1_cyc_i;
            wbs0_stb_i = wbs0_cyc_i & $urandom_range(1);
            wbs1_stb_i = wbs1_cyc_i & $urandom_range(1);
            wbs0_adr_i = AW'($urandom); wbs1_adr_i = AW'($urandom);
            wbs0_dat_i = $urandom; wbs1_dat_i = $urandom; wbm_dat_i = $urandom;
            wbs0_we_i = $urandom_range(1); wbs1_we_i = $urandom_range(1);
            wbm_stall_i = ($urandom_range(3) == 0);
            if (mq.size() > 0 && wait_cnt >= 4) wbm_ack_i = 1;
            else wbm_ack_i = ($urandom_range(9) < 3);
            wbm_err_i = !wbm_ack_i && ($urandom_range(19) == 0);
            #2;
            model_check(t);
            @(posedge clk);
            if (mq.size() > 0 && mg >= 0 && !(wbm_ack_i | wbm_err_i)) wait_cnt++;
            else wait_cnt = 0;
            model_step();
            #1;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
